// File: rtl/wordcount_word_splitter.sv
// -----------------------------------------------------------------------------
// wordcount_word_splitter
// Splits 512-bit AXI4-Stream beats from the read master into WORD_WIDTH lanes
// and presents them one word per cycle on a valid/ready port. Emission stops
// after num_words words. Unused lanes and any surplus beats up to tlast are
// consumed and dropped, so the read master always completes its transfer.
//
// Ports
//   ap_clk, areset           clock, synchronous active-high reset
//   start, num_words         run kick (IDLE only) and word budget
//   busy, done, err_short    run status: active, one-cycle completion,
//                            sticky "tlast arrived before budget reached"
//   s_axis_*                 input beat stream (tvalid/tready/tdata/tlast)
//   m_word_*                 output word stream (valid/ready/data/last/index)
// -----------------------------------------------------------------------------
module wordcount_word_splitter #(
    parameter int DATA_WIDTH  = 512,
    parameter int WORD_WIDTH  = 128,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   ap_clk,
    input  logic                   areset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_words,
    output logic                   busy,
    output logic                   done,
    output logic                   err_short,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tlast,
    output logic                   m_word_valid,
    input  logic                   m_word_ready,
    output logic [WORD_WIDTH-1:0]  m_word_data,
    output logic                   m_word_last,
    output logic [COUNT_WIDTH-1:0] m_word_index
);

    localparam int LANES  = DATA_WIDTH / WORD_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0]      LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [COUNT_WIDTH-1:0] ONE_WORD  = COUNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EMIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [DATA_WIDTH-1:0]  hold_r;
    logic                   beat_last_r;
    logic [LANE_W-1:0]      lane_r;
    logic [COUNT_WIDTH-1:0] remaining_r;
    logic [COUNT_WIDTH-1:0] index_r;
    logic                   err_short_r;

    logic                   tready_s;
    logic                   word_hs_s;
    logic                   beat_hs_s;
    logic                   set_err_s;
    logic                   at_last_lane_s;
    logic                   final_word_s;

    assign at_last_lane_s = (lane_r == LAST_LANE);
    assign final_word_s   = (remaining_r == ONE_WORD);

    // State register.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and handshake strobes.
    always_comb begin
        state_nxt_s = state_r;
        tready_s    = 1'b0;
        word_hs_s   = 1'b0;
        set_err_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_LOAD;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                tready_s = 1'b1;
                if (s_axis_tvalid) begin
                    state_nxt_s = S_EMIT;
                end else begin
                    state_nxt_s = S_LOAD;
                end
            end
            S_EMIT: begin
                // Prefetch the next beat while the last lane drains so that
                // consecutive beats stream without a LOAD bubble.
                tready_s  = at_last_lane_s && m_word_ready &&
                            (remaining_r > ONE_WORD) && !beat_last_r;
                word_hs_s = m_word_ready;
                if (m_word_ready) begin
                    if (final_word_s) begin
                        if (beat_last_r) begin
                            state_nxt_s = S_DONE;
                        end else begin
                            state_nxt_s = S_DRAIN;
                        end
                    end else if (at_last_lane_s) begin
                        if (beat_last_r) begin
                            set_err_s   = 1'b1;
                            state_nxt_s = S_DONE;
                        end else if (s_axis_tvalid) begin
                            state_nxt_s = S_EMIT;
                        end else begin
                            state_nxt_s = S_LOAD;
                        end
                    end else begin
                        state_nxt_s = S_EMIT;
                    end
                end else begin
                    state_nxt_s = S_EMIT;
                end
            end
            S_DRAIN: begin
                tready_s = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
        beat_hs_s = tready_s && s_axis_tvalid;
    end

    // Holding register, lane pointer, word counters and sticky error flag.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            hold_r      <= '0;
            beat_last_r <= 1'b0;
            lane_r      <= '0;
            remaining_r <= '0;
            index_r     <= '0;
            err_short_r <= 1'b0;
        end else begin
            if ((state_r == S_IDLE) && start) begin
                remaining_r <= num_words;
                index_r     <= '0;
                err_short_r <= 1'b0;
            end else begin
                if (word_hs_s) begin
                    if (remaining_r != '0) begin
                        remaining_r <= remaining_r - ONE_WORD;
                    end
                    index_r <= index_r + ONE_WORD;
                end
                if (set_err_s) begin
                    err_short_r <= 1'b1;
                end
            end
            // Beats accepted in DRAIN are discarded; all others are captured.
            if (beat_hs_s && (state_r != S_DRAIN)) begin
                hold_r      <= s_axis_tdata;
                beat_last_r <= s_axis_tlast;
                lane_r      <= '0;
            end else if (word_hs_s) begin
                lane_r <= lane_r + LANE_W'(1);
            end
        end
    end

    // Outputs decode from registered state; only s_axis_tready sees m_word_ready.
    assign busy          = (state_r == S_LOAD) || (state_r == S_EMIT) || (state_r == S_DRAIN);
    assign done          = (state_r == S_DONE);
    assign err_short     = err_short_r;
    assign s_axis_tready = tready_s;
    assign m_word_valid  = (state_r == S_EMIT);
    assign m_word_data   = m_word_valid ? hold_r[lane_r * WORD_WIDTH +: WORD_WIDTH] : '0;
    assign m_word_last   = m_word_valid && final_word_s;
    assign m_word_index  = m_word_valid ? index_r : '0;

endmodule
